// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame definitions for the transmit and receive halves
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input logic typ);
    return (^d) ^ (typ == PAR_ODD);
  endfunction
endpackage

// File: rtl/uart_tx_baud_cnt.sv
// uart_tx_baud_cnt: bit-period counter, counts 0..period_m1 while enabled
// Ports: CLK/RST clock and sync reset; enable runs the counter; period_m1 is the
// terminal count; cnt is the position within the bit; bit_end flags the last clock.
module uart_tx_baud_cnt (
  input  logic       CLK,
  input  logic       RST,
  input  logic       enable,
  input  logic [5:0] period_m1,
  output logic [5:0] cnt,
  output logic       bit_end
);
  assign bit_end = enable && cnt == period_m1;
  always_ff @(posedge CLK) begin
    if (RST || !enable || bit_end) cnt <= '0;
    else cnt <= cnt + 6'd1;
  end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, start + 8 data LSB-first + optional parity + stop
// Ports: CLK/RST clock and sync reset; P_DATA/DATA_VALID byte handshake;
// PAR_EN/PAR_TYP parity control; Prescale bit period (0 = 64); TX_OUT serial
// line (idle high); Busy high while a frame is on the line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int PRESCALE = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DATA_BITS-1:0] P_DATA,
  input  logic                 DATA_VALID,
  input  logic                 PAR_EN,
  input  logic                 PAR_TYP,
  input  logic [5:0]           Prescale,
  output logic                 TX_OUT,
  output logic                 Busy
);
  if (PRESCALE < 1 || PRESCALE > 64) begin : g_bad_prescale
    $error("uart_tx: PRESCALE must be 1..64");
  end
  uart_state_e          state;
  logic [DATA_BITS-1:0] data;
  logic                 par_en;
  logic                 par_bit;
  logic [5:0]           period_m1;
  logic [2:0]           idx;
  logic [5:0]           cnt;
  logic                 bit_end;
  logic                 tx_bit;
  uart_tx_baud_cnt u_baud (
    .CLK       (CLK),
    .RST       (RST),
    .enable    (state != IDLE),
    .period_m1 (period_m1),
    .cnt       (cnt),
    .bit_end   (bit_end)
  );
  // Outputs are registered from the state, so the line trails the FSM by one clock.
  always_comb
    tx_bit = state == START  ? 1'b0 :
             state == DATA   ? data[idx] :
             state == PARITY ? par_bit : 1'b1;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      TX_OUT    <= 1'b1;
      Busy      <= 1'b0;
      data      <= '0;
      par_en    <= 1'b0;
      par_bit   <= 1'b0;
      period_m1 <= '0;
      idx       <= '0;
    end else begin
      TX_OUT <= tx_bit;
      Busy   <= state != IDLE;
      case (state)
        IDLE: if (DATA_VALID) begin
          data      <= P_DATA;
          par_en    <= PAR_EN;
          par_bit   <= parity_bit(P_DATA, PAR_TYP);
          period_m1 <= Prescale - 6'd1;
          idx       <= '0;
          state     <= START;
        end
        START: if (bit_end) state <= DATA;
        DATA: if (bit_end) begin
          idx <= idx + 3'd1;
          if (idx == 3'(DATA_BITS - 1)) state <= par_en ? PARITY : STOP;
        end
        PARITY: if (bit_end) state <= STOP;
        STOP: if (bit_end) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  logic unused_cnt;
  assign unused_cnt = ^cnt;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized self-checking bench for uart_tx against a frame-level model
module tb_uart_tx;
  logic       CLK = 0;
  logic       RST = 1;
  logic [7:0] P_DATA = '0;
  logic       DATA_VALID = 0;
  logic       PAR_EN = 0;
  logic       PAR_TYP = 0;
  logic [5:0] Prescale = 6'd8;
  logic       TX_OUT;
  logic       Busy;
  int tests = 0;
  int fails = 0;
  logic exp_tx[$];
  logic exp_busy[$];

  uart_tx dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  always #5 CLK = ~CLK;

  // Appends the per-clock line/busy waveform of one frame, built from the frame rules.
  function automatic void add_frame(input logic [7:0] d, input logic pe, input logic pt, input int p);
    logic bits[$];
    int ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pe) bits.push_back(((ones % 2) == 1) != pt);
    bits.push_back(1'b1);
    foreach (bits[b])
      for (int c = 0; c < p; c++) begin
        exp_tx.push_back(bits[b]);
        exp_busy.push_back(1'b1);
      end
  endfunction

  // Sends one frame and checks every clock; noisy mode scrambles inputs mid-frame.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input logic [5:0] pr, input bit noisy, input string nm);
    int p;
    int n;
    p = (pr == 0) ? 64 : int'(pr);
    exp_tx.delete();
    exp_busy.delete();
    add_frame(d, pe, pt, p);
    n = exp_tx.size();
    @(negedge CLK);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Prescale = pr; DATA_VALID = 1;
    @(posedge CLK);
    @(negedge CLK);
    DATA_VALID = 0;
    tests++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      fails++;
      $display("FAIL %s latency: tx=%b busy=%b want tx=1 busy=0", nm, TX_OUT, Busy);
    end
    for (int j = 0; j < n; j++) begin
      @(negedge CLK);
      tests++;
      if (TX_OUT !== exp_tx[j] || Busy !== exp_busy[j]) begin
        fails++;
        $display("FAIL %s clk %0d: tx=%b busy=%b want tx=%b busy=%b", nm, j, TX_OUT, Busy, exp_tx[j], exp_busy[j]);
      end
      if (noisy && j < n - 2) begin
        P_DATA = 8'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
        Prescale = 6'($urandom); DATA_VALID = 1'($urandom);
      end else DATA_VALID = 0;
    end
    for (int j = 0; j < p + 4; j++) begin
      @(negedge CLK);
      tests++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
        fails++;
        $display("FAIL %s idle %0d: tx=%b busy=%b want tx=1 busy=0", nm, j, TX_OUT, Busy);
      end
    end
  endtask

  task automatic test_reset();
    RST = 1; DATA_VALID = 0;
    repeat (3) @(negedge CLK);
    tests++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      fails++;
      $display("FAIL reset: tx=%b busy=%b want tx=1 busy=0", TX_OUT, Busy);
    end
    RST = 0;
  endtask

  task automatic test_directed();
    send_frame(8'hA5, 1, 0, 6'd8, 0, "a5_even");
    send_frame(8'hA5, 1, 1, 6'd8, 0, "a5_odd");
    send_frame(8'h00, 0, 0, 6'd16, 0, "zero_p16");
    send_frame(8'h5C, 1, 1, 6'd1, 0, "p1");
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++)
      send_frame(8'($urandom), 1'($urandom), 1'($urandom), 6'($urandom_range(1, 12)), 0, "random");
  endtask

  task automatic test_mid_frame_changes();
    for (int i = 0; i < 3; i++)
      send_frame(8'($urandom), 1'($urandom), 1'($urandom), 6'($urandom_range(2, 10)), 1, "noisy");
  endtask

  task automatic test_prescale_zero();
    send_frame(8'($urandom), 1, 0, 6'd0, 0, "p64");
  endtask

  task automatic test_back_to_back();
    exp_tx.delete();
    exp_busy.delete();
    add_frame(8'h01, 0, 0, 4);
    exp_tx.push_back(1'b1);
    exp_busy.push_back(1'b0);
    add_frame(8'h80, 0, 0, 4);
    @(negedge CLK);
    P_DATA = 8'h01; PAR_EN = 0; PAR_TYP = 0; Prescale = 6'd4; DATA_VALID = 1;
    @(posedge CLK);
    @(negedge CLK);
    P_DATA = 8'h80;
    for (int j = 0; j < exp_tx.size(); j++) begin
      @(negedge CLK);
      tests++;
      if (TX_OUT !== exp_tx[j] || Busy !== exp_busy[j]) begin
        fails++;
        $display("FAIL b2b clk %0d: tx=%b busy=%b want tx=%b busy=%b", j, TX_OUT, Busy, exp_tx[j], exp_busy[j]);
      end
      if (j == 40) DATA_VALID = 0;
    end
    repeat (8) begin
      @(negedge CLK);
      tests++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
        fails++;
        $display("FAIL b2b tail: tx=%b busy=%b want tx=1 busy=0", TX_OUT, Busy);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge CLK);
    P_DATA = 8'h00; PAR_EN = 1; PAR_TYP = 0; Prescale = 6'd8; DATA_VALID = 1;
    @(posedge CLK);
    @(negedge CLK);
    DATA_VALID = 0;
    repeat (35) @(negedge CLK);
    tests++;
    if (TX_OUT !== 1'b0 || Busy !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset bit3: tx=%b busy=%b want tx=0 busy=1", TX_OUT, Busy);
    end
    RST = 1;
    @(negedge CLK);
    RST = 0;
    tests++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: tx=%b busy=%b want tx=1 busy=0", TX_OUT, Busy);
    end
    repeat (100) begin
      @(negedge CLK);
      tests++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
        fails++;
        $display("FAIL no_resume: tx=%b busy=%b want tx=1 busy=0", TX_OUT, Busy);
      end
    end
  endtask

  task automatic test_reset_with_valid();
    @(negedge CLK);
    RST = 1; DATA_VALID = 1; P_DATA = 8'h00; Prescale = 6'd3;
    @(negedge CLK);
    RST = 0; DATA_VALID = 0;
    repeat (6) begin
      @(negedge CLK);
      tests++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
        fails++;
        $display("FAIL reset_wins: tx=%b busy=%b want tx=1 busy=0", TX_OUT, Busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_mid_frame_changes();
    test_back_to_back();
    test_reset_mid_frame();
    test_reset_with_valid();
    test_prescale_zero();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter, the transmit half of the system UART, paired with the `UART_RX` receiver. It accepts one byte per handshake and serialises it LSB-first as start, 8 data bits, optional parity and one stop bit on `TX_OUT`. Frame format and bit period match the receiver's `PAR_EN`, `PAR_TYP` and `Prescale` settings. The system register file or FIFO read side drives it in the UART clock domain.

## Interface
- `PRESCALE`, default 32: default bit period in clocks. It is used only for documentation and for bench defaults; the runtime period comes from `Prescale`.
- `CLK` in 1: UART clock. All logic is on the rising edge.
- `RST` in 1: synchronous, active-high reset. One clock, `RST` sampled on `CLK`.
- `P_DATA` in 8: byte to transmit.
- `DATA_VALID` in 1: `P_DATA` is valid and requests a transmission.
- `PAR_EN` in 1: 1 appends a parity bit.
- `PAR_TYP` in 1: 0 selects even parity, 1 selects odd parity.
- `Prescale` in 6: bit period in clocks. Value 0 means 64.
- `TX_OUT` out 1: serial line. Registered, idle-high.
- `Busy` out 1: registered. High while a frame is in progress.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Reset values: state IDLE, `TX_OUT`=1, `Busy`=0, counters 0, latched registers 0.
- Accept: `DATA_VALID`=1 while in IDLE.
  - On that edge, latch `P_DATA`, `PAR_EN`, `PAR_TYP` and the effective period P (P = `Prescale`, or 64 if `Prescale`=0).
  - Compute the parity bit at latch time: even = XOR of the data bits; odd = inverted XOR.
- The frame uses only the latched values. Input changes mid-frame have no effect.
- `DATA_VALID` while not in IDLE is ignored. There is no buffering, and the upstream block must hold data until it is accepted.
- Bit-period counter `cnt` counts 0..P-1 in every non-IDLE state. A bit ends when `cnt`=P-1; then `cnt` returns to 0.
- `TX_OUT` value per state:
  - START: 0.
  - DATA: `data[idx]`, where `idx` (3 bits) counts 0..7 and advances at each bit end.
  - PARITY: latched parity bit.
  - STOP: 1.
  - IDLE: 1.
- Transitions, each taken at the bit end:
  - IDLE to START on accept.
  - START to DATA.
  - DATA to PARITY at `idx`=7 if PAR_EN was latched as 1; otherwise DATA to STOP.
  - PARITY to STOP.
  - STOP to IDLE.
- `Busy` = 1 in every state except IDLE. It is registered and therefore aligned with `TX_OUT`.

## Timing
- Accept on edge k: `TX_OUT` falls and `Busy` rises at edge k+1.
- Each bit holds for exactly P clocks.
- Frame length: 10·P clocks without parity, 11·P with parity, from the `TX_OUT` fall to the stop-bit end.
- `Busy` falls at the same edge the stop bit ends, so `TX_OUT` stays 1.
- Next-frame timing with `DATA_VALID` held continuously high:
  - The next accept happens on the first IDLE edge.
  - There is one idle-high clock between frames.
  - Frame period is 10·P+1 or 11·P+1 clocks.
- Reset mid-frame: at the next edge, `TX_OUT`=1, `Busy`=0 and state is IDLE. The frame is truncated and not resumed.
- `RST` and `DATA_VALID` in the same cycle: reset wins and nothing is accepted.
- Width rules:
  - `cnt` is 6 bits; P=64 uses terminal count 63.
  - Compute P-1 in 7 bits, or as `Prescale`-1 with 0 wrapping to 63.
  - P=1 is legal: one clock per bit.

## Structure
- Shared package `uart_pkg` holds:
  - state encodings, shared with `UART_RX`;
  - `PAR_EVEN`=0 and `PAR_ODD`=1;
  - `DATA_BITS`=8.
- One sub-module, `uart_tx_baud_cnt`.
  - Inputs: `CLK`, `RST`, `enable`, `period_m1[5:0]`.
  - Outputs: `cnt` and the `bit_end` pulse.
- The FSM, shift/index logic and parity logic stay in `uart_tx`.

## Test plan
- 0xA5, `PAR_EN`=1, `PAR_TYP`=0, `Prescale`=8 -> `TX_OUT` = 0,1,0,1,0,0,1,0,1,0,1, each bit 8 clocks. `Busy` is high for 88 clocks.
- Same frame with `PAR_TYP`=1 -> parity bit 1; all other bits unchanged.
- 0x00, `PAR_EN`=0, `Prescale`=16 -> 0 for 144 clocks, then 1 for 16 clocks. `Busy` is high for 160 clocks.
- `DATA_VALID` held high with bytes 0x01 then 0x80, `Prescale`=4, no parity -> two frames. Second start bit falls 41 clocks after the first. The second byte is taken only on the IDLE edge.
- Mid-frame changes of `P_DATA`, `PAR_EN` and `Prescale`, plus `DATA_VALID` pulses while `Busy` -> frame unchanged and no extra frame sent.
- `RST` asserted in bit 3 of a frame -> `TX_OUT`=1 and `Busy`=0 one edge later. `Prescale`=0 -> each bit holds 64 clocks.
